// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + carry_in, DIGIT bits per clock through one ripple slice.
// Start/busy/done handshake; sum, carry_out and overflow are held between completions.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// RUN    | one DIGIT slice added per edge, N = WIDTH/DIGIT edges
// DONE   | done pulse cycle; start here is accepted back-to-back
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic [DIGIT:0]     w_slice;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_b_next;
    logic               w_ovf;

    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

    // Result digits enter r_a from the top as operand digits leave at the bottom,
    // so after N edges r_a holds the complete result.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_a_next = w_slice[DIGIT-1:0];
            assign w_b_next = '0;
        end else begin : g_multi
            assign w_a_next = {w_slice[DIGIT-1:0], r_a[WIDTH-1:DIGIT]};
            assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_ovf = (r_a_msb == r_b_msb) && (w_a_next[WIDTH-1] != r_a_msb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carry_in;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_slice[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        sum       <= w_a_next;
                        carry_out <= w_slice[DIGIT];
                        overflow  <= w_ovf;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three configurations (4/1, 8/1, 8/4) checked
// against an arithmetic reference of a + b + carry_in with signed-range overflow.
module tb_serial_adder;

    logic clk;
    logic rst;

    logic       s4_start, s4_cin, s4_busy, s4_done, s4_co, s4_ov;
    logic [3:0] s4_a, s4_b, s4_sum;
    logic       s8_start, s8_cin, s8_busy, s8_done, s8_co, s8_ov;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s84_start, s84_cin, s84_busy, s84_done, s84_co, s84_ov;
    logic [7:0] s84_a, s84_b, s84_sum;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .reset(rst), .start(s4_start), .a(s4_a), .b(s4_b), .carry_in(s4_cin),
        .busy(s4_busy), .done(s4_done), .sum(s4_sum), .carry_out(s4_co), .overflow(s4_ov));

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .reset(rst), .start(s8_start), .a(s8_a), .b(s8_b), .carry_in(s8_cin),
        .busy(s8_busy), .done(s8_done), .sum(s8_sum), .carry_out(s8_co), .overflow(s8_ov));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .reset(rst), .start(s84_start), .a(s84_a), .b(s84_b), .carry_in(s84_cin),
        .busy(s84_busy), .done(s84_done), .sum(s84_sum), .carry_out(s84_co), .overflow(s84_ov));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full unsigned result, and signed-range overflow.
    function automatic int ref_full(input int ua, input int ub, input int c);
        return ua + ub + c;
    endfunction

    function automatic logic ref_ov(input int w, input int ua, input int ub, input int c);
        int sa, sb, t;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        t  = sa + sb + c;
        return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    endfunction

    // Drivers: called just after a rising edge; return results at the done cycle,
    // edges counted from acceptance to done, and done seen in the first cycle after acceptance.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       output logic [3:0] rs, output logic rco, output logic rov,
                       output int lat, output logic d0);
        s4_a = ta; s4_b = tb; s4_cin = tc; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        d0 = s4_done;
        lat = 0;
        while (s4_done !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s4_sum; rco = s4_co; rov = s4_ov;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       output logic [7:0] rs, output logic rco, output logic rov,
                       output int lat);
        s8_a = ta; s8_b = tb; s8_cin = tc; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        lat = 0;
        while (s8_done !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s8_sum; rco = s8_co; rov = s8_ov;
    endtask

    task automatic op84(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output logic [7:0] rs, output logic rco, output logic rov,
                        output int lat);
        s84_a = ta; s84_b = tb; s84_cin = tc; s84_start = 1'b1;
        @(posedge clk); #1;
        s84_start = 1'b0;
        lat = 0;
        while (s84_done !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s84_sum; rco = s84_co; rov = s84_ov;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s4_start = 0;  s4_a = 0;  s4_b = 0;  s4_cin = 0;
        s8_start = 0;  s8_a = 0;  s8_b = 0;  s8_cin = 0;
        s84_start = 0; s84_a = 0; s84_b = 0; s84_cin = 0;
        #12;
        n_checks++;
        if ({s4_busy, s4_done, s4_co, s4_ov, s4_sum} !== 8'h00) begin
            n_fail++; $display("FAIL reset_u4: got %b expected 0", {s4_busy, s4_done, s4_co, s4_ov, s4_sum});
        end
        n_checks++;
        if ({s8_busy, s8_done, s8_co, s8_ov, s8_sum} !== 12'h000) begin
            n_fail++; $display("FAIL reset_u8: got %b expected 0", {s8_busy, s8_done, s8_co, s8_ov, s8_sum});
        end
        n_checks++;
        if ({s84_busy, s84_done, s84_co, s84_ov, s84_sum} !== 12'h000) begin
            n_fail++; $display("FAIL reset_u84: got %b expected 0", {s84_busy, s84_done, s84_co, s84_ov, s84_sum});
        end
        s8_start = 1'b1; s8_a = 8'h11; s8_b = 8'h22;
        @(posedge clk); #1;
        n_checks++;
        if (s8_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins_over_start: busy=%b expected 0", s8_busy);
        end
        s8_start = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive4();
        logic [3:0] rs;
        logic rco, rov, d0;
        int lat, full;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic), rs, rco, rov, lat, d0);
                    full = ref_full(ia, ib, ic);
                    n_checks++;
                    if ({rco, rs} !== 5'(full)) begin
                        n_fail++; $display("FAIL exh4_sum a=%0d b=%0d c=%0d: got %h expected %h", ia, ib, ic, {rco, rs}, 5'(full));
                    end
                    n_checks++;
                    if (rov !== ref_ov(4, ia, ib, ic)) begin
                        n_fail++; $display("FAIL exh4_ovf a=%0d b=%0d c=%0d: got %b expected %b", ia, ib, ic, rov, ref_ov(4, ia, ib, ic));
                    end
                    n_checks++;
                    if (lat != 4) begin
                        n_fail++; $display("FAIL exh4_latency a=%0d b=%0d c=%0d: got %0d expected 4", ia, ib, ic, lat);
                    end
                    n_checks++;
                    if (d0 !== 1'b0) begin
                        n_fail++; $display("FAIL exh4_done_pulse a=%0d b=%0d c=%0d: done=%b after accept, expected 0", ia, ib, ic, d0);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry_wrap();
        s8_a = 8'hFF; s8_b = 8'h01; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (s8_busy !== 1'b1 || s8_done !== 1'b0) begin
                n_fail++; $display("FAIL wrap_busy cycle %0d: busy=%b done=%b expected 1/0", i + 1, s8_busy, s8_done);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({s8_done, s8_busy, s8_co, s8_ov, s8_sum} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL wrap_result: done/busy/co/ov/sum=%b expected 1010_00000000", {s8_done, s8_busy, s8_co, s8_ov, s8_sum});
        end
        @(posedge clk); #1;
        n_checks++;
        if (s8_done !== 1'b0) begin
            n_fail++; $display("FAIL wrap_done_width: done=%b expected 0", s8_done);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rs;
        logic rco, rov;
        int lat;
        op8(8'h7F, 8'h01, 1'b0, rs, rco, rov, lat);
        n_checks++;
        if ({rco, rov, rs} !== {1'b0, 1'b1, 8'h80}) begin
            n_fail++; $display("FAIL ovf_pos: co/ov/sum=%b %b %h expected 0 1 80", rco, rov, rs);
        end
        op8(8'h80, 8'h80, 1'b0, rs, rco, rov, lat);
        n_checks++;
        if ({rco, rov, rs} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL ovf_neg: co/ov/sum=%b %b %h expected 1 1 00", rco, rov, rs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int dones, first;
        s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s8_a = 8'hFF; s8_b = 8'hFF; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        dones = 0; first = -1;
        for (int i = 3; i < 25; i++) begin
            if (s8_done === 1'b1) begin
                dones++;
                if (first < 0) first = i;
                n_checks++;
                if ({s8_co, s8_sum} !== 9'h046) begin
                    n_fail++; $display("FAIL ignore_result: co/sum=%b %h expected 0 46", s8_co, s8_sum);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
        n_checks++;
        if (first != 8) begin
            n_fail++; $display("FAIL ignore_latency: got %0d expected 8", first);
        end
        n_checks++;
        if (s8_busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_no_restart: busy=%b expected 0", s8_busy);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] rs;
        logic rco, rov;
        int lat, dones;
        op8(8'h80, 8'h81, 1'b0, rs, rco, rov, lat);
        n_checks++;
        if ({rco, rov, rs} !== {1'b1, 1'b1, 8'h01}) begin
            n_fail++; $display("FAIL areset_setup: co/ov/sum=%b %b %h expected 1 1 01", rco, rov, rs);
        end
        s8_a = 8'h55; s8_b = 8'h22; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({s8_busy, s8_done, s8_co, s8_ov, s8_sum} !== 12'h000) begin
            n_fail++; $display("FAIL areset_immediate: busy/done/co/ov/sum=%b expected 0", {s8_busy, s8_done, s8_co, s8_ov, s8_sum});
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (s8_done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL areset_no_done: got %0d done pulses expected 0", dones);
        end
        op8(8'h01, 8'h02, 1'b0, rs, rco, rov, lat);
        n_checks++;
        if ({rco, rov, rs} !== {1'b0, 1'b0, 8'h03} || lat != 8) begin
            n_fail++; $display("FAIL areset_recover: co/ov/sum=%b %b %h lat=%0d expected 0 0 03 lat 8", rco, rov, rs, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_digit4();
        logic [7:0] rs;
        logic rco, rov;
        int lat, full;
        op84(8'h11, 8'h22, 1'b0, rs, rco, rov, lat);
        n_checks++;
        if (rs !== 8'h33 || lat != 2) begin
            n_fail++; $display("FAIL d4_setup: sum=%h lat=%0d expected 33 lat 2", rs, lat);
        end
        s84_a = 8'hA5; s84_b = 8'h5A; s84_cin = 1'b1; s84_start = 1'b1;
        @(posedge clk); #1;
        s84_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (s84_busy !== 1'b1 || s84_done !== 1'b0 || s84_sum !== 8'h33) begin
                n_fail++; $display("FAIL d4_hold cycle %0d: busy=%b done=%b sum=%h expected 1 0 33", i + 1, s84_busy, s84_done, s84_sum);
            end
            @(posedge clk); #1;
        end
        full = ref_full(8'hA5, 8'h5A, 1);
        n_checks++;
        if ({s84_done, s84_busy, s84_co, s84_sum} !== {1'b1, 1'b0, 9'(full)}) begin
            n_fail++; $display("FAIL d4_result: done/busy/co/sum=%b %b %b %h expected 1 0 %h", s84_done, s84_busy, s84_co, s84_sum, 9'(full));
        end
        n_checks++;
        if (s84_ov !== ref_ov(8, 8'hA5, 8'h5A, 1)) begin
            n_fail++; $display("FAIL d4_ovf: got %b expected %b", s84_ov, ref_ov(8, 8'hA5, 8'h5A, 1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] rs, ra, rb;
        logic rco, rov, rc;
        int lat, full;
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8(ra, rb, rc, rs, rco, rov, lat);
            full = ref_full(int'(ra), int'(rb), int'(rc));
            n_checks++;
            if ({rco, rs} !== 9'(full) || rov !== ref_ov(8, int'(ra), int'(rb), int'(rc)) || lat != 8) begin
                n_fail++; $display("FAIL rand8 %h+%h+%b: co/sum=%h ov=%b lat=%0d expected %h ov=%b lat 8",
                                   ra, rb, rc, {rco, rs}, rov, lat, 9'(full), ref_ov(8, int'(ra), int'(rb), int'(rc)));
            end
        end
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op84(ra, rb, rc, rs, rco, rov, lat);
            full = ref_full(int'(ra), int'(rb), int'(rc));
            n_checks++;
            if ({rco, rs} !== 9'(full) || rov !== ref_ov(8, int'(ra), int'(rb), int'(rc)) || lat != 2) begin
                n_fail++; $display("FAIL rand84 %h+%h+%b: co/sum=%h ov=%b lat=%0d expected %h ov=%b lat 2",
                                   ra, rb, rc, {rco, rs}, rov, lat, 9'(full), ref_ov(8, int'(ra), int'(rb), int'(rc)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive4();
        test_carry_wrap();
        test_overflow();
        test_start_ignored();
        test_async_reset();
        test_digit4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
